pap_pht_update_queue: RTL and testbench

- Execution-side writer for the per-address (PAp) pattern history table.
- Accepts up to two resolved conditional-branch results per cycle from the integer pipes and computes saturated counter updates.
- Buffers the updates in an in-order queue and drains them onto the PHT write ports, never writing the same entry twice in one cycle.
- Also issues per-address history repairs on misprediction and runs the post-reset PHT initialisation sweep.

---
 rtl/pap_pht_update_queue_if.sv | 41 ++++
 rtl/pap_pht_update_queue.sv | 162 ++++++++++++++++
 tb/tb_pap_pht_update_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pap_pht_update_queue_if.sv
// Branch-result, PHT write and history-repair signals of the PAp PHT update queue.
// The master modport is the execution side; the slave modport is the queue itself.
interface pap_pht_update_queue_if #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 2,
  parameter int CTR_W  = 2
) ();
  logic [1:0]             br_valid;
  logic [1:0][31:0]       br_addr;
  logic [1:0]             br_cond;
  logic [1:0]             br_taken;
  logic [1:0]             br_mispred;
  logic [1:0][HIST_W-1:0] br_prev_hist;
  logic [1:0][CTR_W-1:0]  br_prev_ctr;
  logic                   ready;

  logic [1:0]             pht_we;
  logic [1:0][IDX_W-1:0]  pht_wa;
  logic [1:0][HIST_W-1:0] pht_wslot;
  logic [1:0][CTR_W-1:0]  pht_wv;
  logic                   pht_winit;

  logic [1:0]             hist_we;
  logic [1:0][IDX_W-1:0]  hist_wa;
  logic [1:0][HIST_W-1:0] hist_wv;

  logic                   init_busy;
  logic                   overflow;

  modport master (
    output br_valid, br_addr, br_cond, br_taken, br_mispred, br_prev_hist, br_prev_ctr,
    input  ready, pht_we, pht_wa, pht_wslot, pht_wv, pht_winit,
    input  hist_we, hist_wa, hist_wv, init_busy, overflow
  );

  modport slave (
    input  br_valid, br_addr, br_cond, br_taken, br_mispred, br_prev_hist, br_prev_ctr,
    output ready, pht_we, pht_wa, pht_wslot, pht_wv, pht_winit,
    output hist_we, hist_wa, hist_wv, init_busy, overflow
  );
endinterface

// File: rtl/pap_pht_update_queue.sv
// PAp PHT writer: turns resolved branches into saturated counter updates, queues them in order,
// drains up to two non-conflicting writes per cycle, repairs per-address history, and sweeps the PHT after reset.
module pap_pht_update_queue #(
  parameter int IDX_W      = 8,
  parameter int HIST_W     = 2,
  parameter int CTR_W      = 2,
  parameter int DEPTH      = 8,
  parameter int INSN_SHIFT = 2
) (
  input logic                   clk,
  input logic                   rst,
  pap_pht_update_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [HIST_W-1:0] slot;
    logic [CTR_W-1:0]  value;
  } phtUpdate_t;

  typedef enum logic {stInit, stRun} fsmState_t;

  fsmState_t        state;
  logic [IDX_W-1:0] sweepIdx;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  phtUpdate_t       mem [DEPTH];

  logic [1:0]       accepted;
  logic [1:0]       repairEn;
  logic [1:0]       enqEn;
  logic [1:0]       deqEn;
  logic [1:0]       enqCount;
  logic [1:0]       deqCount;
  logic [CNT_W-1:0] countNext;
  logic [IDX_W-1:0] laneIdx [2];
  phtUpdate_t       laneUpd [2];
  phtUpdate_t       headUpd;
  phtUpdate_t       nextUpd;

  // Address bits outside the index field carry no information for this table.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.br_addr[0][31:IDX_W+INSN_SHIFT], bus.br_addr[0][INSN_SHIFT-1:0],
                            bus.br_addr[1][31:IDX_W+INSN_SHIFT], bus.br_addr[1][INSN_SHIFT-1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    accepted = '0;
    repairEn = '0;
    for (int l = 0; l < 2; l++) begin
      laneIdx[l]       = bus.br_addr[l][IDX_W+INSN_SHIFT-1:INSN_SHIFT];
      accepted[l]      = bus.br_valid[l] & bus.br_cond[l];
      repairEn[l]      = accepted[l] & bus.br_mispred[l];
      laneUpd[l].idx   = laneIdx[l];
      laneUpd[l].slot  = bus.br_prev_hist[l];
      if (bus.br_taken[l])
        laneUpd[l].value = (bus.br_prev_ctr[l] == CTR_MAX) ? CTR_MAX : bus.br_prev_ctr[l] + CTR_W'(1);
      else
        laneUpd[l].value = (bus.br_prev_ctr[l] == '0) ? '0 : bus.br_prev_ctr[l] - CTR_W'(1);
    end
    // The younger lane's repair carries the final history when both hit one entry.
    if ((&repairEn) && (laneIdx[0] == laneIdx[1]))
      repairEn[0] = 1'b0;
  end

  // Head+1 may share a port cycle with the head only if it targets a different entry.
  assign headUpd   = mem[rdPtr];
  assign nextUpd   = mem[rdPtr + PTR_W'(1)];
  assign deqEn[0]  = (count != '0);
  assign deqEn[1]  = (count > CNT_W'(1)) && (nextUpd.idx != headUpd.idx);
  assign enqEn     = accepted & {2{bus.ready}};
  assign enqCount  = {1'b0, enqEn[0]} + {1'b0, enqEn[1]};
  assign deqCount  = {1'b0, deqEn[0]} + {1'b0, deqEn[1]};
  assign countNext = count + CNT_W'(enqCount) - CNT_W'(deqCount);

  // NOTE: queue storage is deliberately not reset; count and the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (enqEn[0]) mem[wrPtr] <= laneUpd[0];
    if (enqEn[1]) mem[wrPtr + PTR_W'(enqEn[0])] <= laneUpd[1];
  end

  // NOTE: sequential state uses <= so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= stInit;
      sweepIdx      <= '0;
      rdPtr         <= '0;
      wrPtr         <= '0;
      count         <= '0;
      bus.overflow  <= 1'b0;
      bus.ready     <= 1'b0;
      bus.init_busy <= 1'b1;
      bus.pht_we    <= '0;
      bus.pht_wa    <= '0;
      bus.pht_wslot <= '0;
      bus.pht_wv    <= '0;
      bus.pht_winit <= 1'b0;
      bus.hist_we   <= '0;
      bus.hist_wa   <= '0;
      bus.hist_wv   <= '0;
    end else begin
      bus.pht_we    <= '0;
      bus.pht_wa    <= '0;
      bus.pht_wslot <= '0;
      bus.pht_wv    <= '0;
      bus.pht_winit <= 1'b0;
      bus.hist_we   <= '0;
      bus.hist_wa   <= '0;
      bus.hist_wv   <= '0;
      if (|(accepted & ~{2{bus.ready}}))
        bus.overflow <= 1'b1;

      case (state)
        stInit: begin
          bus.pht_we[0] <= 1'b1;
          bus.pht_winit <= 1'b1;
          bus.pht_wa[0] <= sweepIdx;
          bus.pht_wv[0] <= CTR_WEAK;
          sweepIdx      <= sweepIdx + IDX_W'(1);
          if (&sweepIdx)
            state <= stRun;
        end
        stRun: begin
          // init_busy is still high on the first RUN cycle, which delays ready by one more cycle.
          bus.init_busy <= 1'b0;
          bus.ready     <= !bus.init_busy && (countNext <= CNT_W'(DEPTH - 2));
          rdPtr         <= rdPtr + PTR_W'(deqCount);
          wrPtr         <= wrPtr + PTR_W'(enqCount);
          count         <= countNext;
          bus.pht_we    <= deqEn;
          if (deqEn[0]) begin
            bus.pht_wa[0]    <= headUpd.idx;
            bus.pht_wslot[0] <= headUpd.slot;
            bus.pht_wv[0]    <= headUpd.value;
          end
          if (deqEn[1]) begin
            bus.pht_wa[1]    <= nextUpd.idx;
            bus.pht_wslot[1] <= nextUpd.slot;
            bus.pht_wv[1]    <= nextUpd.value;
          end
          if (!bus.init_busy) begin
            bus.hist_we <= repairEn;
            for (int l = 0; l < 2; l++) begin
              if (repairEn[l]) begin
                bus.hist_wa[l] <= laneIdx[l];
                bus.hist_wv[l] <= {bus.br_prev_hist[l][HIST_W-2:0], bus.br_taken[l]};
              end
            end
          end
        end
        default: state <= stInit;
      endcase
    end
  end

endmodule

// File: tb/tb_pap_pht_update_queue.sv
// Self-checking bench for pap_pht_update_queue: directed vector table, hand-written corner
// sequences, and random traffic compared against a queue-level reference model.
module tb_pap_pht_update_queue;

  localparam int IDX_W = 8;
  localparam int HIST_W = 2;
  localparam int CTR_W = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [1:0]       valid, cond, taken, mispred;
    logic [1:0][31:0] addr;
    logic [1:0][1:0]  hist, ctr;
  } vec_t;

  typedef struct {
    vec_t       in;
    logic [1:0] phtWe;
    logic [7:0] wa;
    logic [1:0] slot, wv;
    logic [1:0] histWe;
    logic [7:0] hwa;
    logic [1:0] hwv;
  } tvec_t;

  typedef struct {
    logic [7:0] idx;
    logic [1:0] slot;
    logic [1:0] val;
  } upd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  upd_t mq[$];
  logic mReady = 1'b0;
  logic mOverflow = 1'b0;

  pap_pht_update_queue_if #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W)) bus ();

  pap_pht_update_queue #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .DEPTH(DEPTH), .INSN_SHIFT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] valid, cond, taken, mispred,
                              input logic [31:0] a0, a1, input logic [1:0] h0, h1, c0, c1);
    vec_t v;
    v.valid = valid; v.cond = cond; v.taken = taken; v.mispred = mispred;
    v.addr[0] = a0; v.addr[1] = a1;
    v.hist[0] = h0; v.hist[1] = h1;
    v.ctr[0] = c0; v.ctr[1] = c1;
    return v;
  endfunction

  function automatic tvec_t mkT(input vec_t in, input logic [1:0] phtWe, input logic [7:0] wa,
                                input logic [1:0] slot, wv, histWe, input logic [7:0] hwa, input logic [1:0] hwv);
    tvec_t t;
    t.in = in; t.phtWe = phtWe; t.wa = wa; t.slot = slot; t.wv = wv;
    t.histWe = histWe; t.hwa = hwa; t.hwv = hwv;
    return t;
  endfunction

  // Saturating counter step computed with plain integer arithmetic.
  function automatic logic [1:0] satNext(input logic [1:0] prev, input logic taken);
    int v;
    v = int'(prev) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.br_valid     = v.valid;
    bus.br_cond      = v.cond;
    bus.br_taken     = v.taken;
    bus.br_mispred   = v.mispred;
    bus.br_addr      = v.addr;
    bus.br_prev_hist = v.hist;
    bus.br_prev_ctr  = v.ctr;
  endtask

  // One clock in RUN: drive inputs, advance the model, compare every output.
  task automatic cycle(input vec_t v);
    logic [1:0] eWe, eHWe;
    logic [1:0][7:0] eWa, eHWa, idx;
    logic [1:0][1:0] eSl, eWv, eHWv;
    upd_t h, s, n;
    drive(v);
    eWe = '0; eWa = '0; eSl = '0; eWv = '0;
    eHWe = '0; eHWa = '0; eHWv = '0;
    if (mq.size() > 0) begin
      h = mq.pop_front();
      eWe[0] = 1'b1; eWa[0] = h.idx; eSl[0] = h.slot; eWv[0] = h.val;
      if (mq.size() > 0 && mq[0].idx != h.idx) begin
        s = mq.pop_front();
        eWe[1] = 1'b1; eWa[1] = s.idx; eSl[1] = s.slot; eWv[1] = s.val;
      end
    end
    for (int l = 0; l < 2; l++) begin
      idx[l] = v.addr[l][9:2];
      eHWe[l] = v.valid[l] & v.cond[l] & v.mispred[l];
    end
    if (eHWe == 2'b11 && idx[0] == idx[1]) eHWe[0] = 1'b0;
    for (int l = 0; l < 2; l++) begin
      if (eHWe[l]) begin
        eHWa[l] = idx[l];
        eHWv[l] = {v.hist[l][0], v.taken[l]};
      end
      if (v.valid[l] && v.cond[l]) begin
        if (mReady) begin
          n.idx = idx[l]; n.slot = v.hist[l]; n.val = satNext(v.ctr[l], v.taken[l]);
          mq.push_back(n);
        end else begin
          mOverflow = 1'b1;
        end
      end
    end
    mReady = (mq.size() <= DEPTH - 2);
    @(posedge clk);
    #1;
    check("pht_port", {bus.pht_we, bus.pht_wa, bus.pht_wslot, bus.pht_wv, bus.pht_winit},
                      {eWe, eWa, eSl, eWv, 1'b0});
    check("hist_repair", {bus.hist_we, bus.hist_wa, bus.hist_wv}, {eHWe, eHWa, eHWv});
    check("ready", bus.ready, mReady);
    check("overflow", bus.overflow, mOverflow);
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_state", {bus.pht_we, bus.pht_winit, bus.hist_we, bus.init_busy, bus.ready, bus.overflow},
                       {2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      @(posedge clk);
      #1;
      check("sweep", {bus.pht_we, bus.pht_winit, bus.pht_wa[0], bus.hist_we, bus.init_busy},
                     {2'b01, 1'b1, 8'(i), 2'b00, 1'b1});
    end
    @(posedge clk);
    #1;
    check("busy_fall", {bus.init_busy, bus.ready, bus.pht_we, bus.pht_winit}, {1'b0, 1'b0, 2'b00, 1'b0});
    @(posedge clk);
    #1;
    check("ready_rise", {bus.init_busy, bus.ready}, {1'b0, 1'b1});
    mq.delete();
    mReady = 1'b1;
    mOverflow = 1'b0;
  endtask

  tvec_t tbl[9];
  vec_t  idle;
  vec_t  rv;
  int    ln;
  int    nFill;
  int    drained;
  int    extraSeen;
  int    k;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = mkT(mk(2'b01, 2'b01, 2'b01, 2'b00, 32'h104, 0, 1, 0, 3, 0), 2'b01, 8'h41, 1, 3, 2'b00, 0, 0);
    tbl[1] = mkT(mk(2'b01, 2'b01, 2'b00, 2'b00, 32'h104, 0, 0, 0, 0, 0), 2'b01, 8'h41, 0, 0, 2'b00, 0, 0);
    tbl[2] = mkT(mk(2'b01, 2'b01, 2'b01, 2'b00, 32'h010, 0, 2, 0, 1, 0), 2'b01, 8'h04, 2, 2, 2'b00, 0, 0);
    tbl[3] = mkT(mk(2'b01, 2'b01, 2'b00, 2'b00, 32'hFFC, 0, 3, 0, 2, 0), 2'b01, 8'hFF, 3, 1, 2'b00, 0, 0);
    tbl[4] = mkT(mk(2'b01, 2'b01, 2'b01, 2'b01, 32'h300, 0, 1, 0, 0, 0), 2'b01, 8'hC0, 1, 1, 2'b01, 8'hC0, 2'b11);
    tbl[5] = mkT(mk(2'b11, 2'b11, 2'b10, 2'b11, 32'h300, 32'h700, 1, 2, 2, 0), 2'b01, 8'hC0, 1, 1, 2'b10, 8'hC0, 2'b01);
    tbl[6] = mkT(mk(2'b01, 2'b00, 2'b01, 2'b01, 32'h104, 0, 1, 0, 1, 0), 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[7] = mkT(mk(2'b01, 2'b10, 2'b00, 2'b11, 32'h104, 32'h108, 1, 1, 1, 1), 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[8] = mkT(mk(2'b11, 2'b11, 2'b11, 2'b00, 32'h020, 32'h024, 0, 1, 2, 3), 2'b11, 8'h08, 0, 3, 2'b00, 0, 0);

    doReset();

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      ln = tbl[i].histWe[1] ? 1 : 0;
      check("tbl_hist", {bus.hist_we, bus.hist_wa[ln], bus.hist_wv[ln]}, {tbl[i].histWe, tbl[i].hwa, tbl[i].hwv});
      cycle(idle);
      check("tbl_pht", {bus.pht_we, bus.pht_wa[0], bus.pht_wslot[0], bus.pht_wv[0]},
                       {tbl[i].phtWe, tbl[i].wa, tbl[i].slot, tbl[i].wv});
    end
    cycle(idle);

    // Same-index pair: port 1 stays idle and the younger update follows a cycle later.
    cycle(mk(2'b11, 2'b11, 2'b11, 2'b00, 32'h200, 32'h200, 0, 3, 1, 2));
    cycle(idle);
    check("conflict_t1", {bus.pht_we, bus.pht_wa[0], bus.pht_wslot[0], bus.pht_wv[0]}, {2'b01, 8'h80, 2'd0, 2'd2});
    cycle(idle);
    check("conflict_t2", {bus.pht_we, bus.pht_wa[0], bus.pht_wslot[0], bus.pht_wv[0]}, {2'b01, 8'h80, 2'd3, 2'd3});
    cycle(idle);

    // Backpressure: same-index pairs drain at one per cycle until ready drops.
    nFill = 0;
    drained = 0;
    extraSeen = 0;
    while (mReady && nFill < 20) begin
      cycle(mk(2'b11, 2'b11, 2'(nFill), 2'b00, 32'h404, 32'h404, 0, 1, 2'(nFill), 2'(nFill + 1)));
      drained += int'(bus.pht_we[0]) + int'(bus.pht_we[1]);
      nFill++;
    end
    check("bp_ready_low", bus.ready, 1'b0);
    cycle(mk(2'b11, 2'b11, 2'b11, 2'b00, 32'h404, 32'h404, 3, 3, 0, 0));
    drained += int'(bus.pht_we[0]) + int'(bus.pht_we[1]);
    check("bp_overflow", bus.overflow, 1'b1);
    k = 0;
    while (mq.size() > 0 && k < 40) begin
      cycle(idle);
      drained += int'(bus.pht_we[0]) + int'(bus.pht_we[1]);
      if (bus.pht_we[0] && bus.pht_wslot[0] == 2'd3) extraSeen++;
      k++;
    end
    cycle(idle);
    drained += int'(bus.pht_we[0]) + int'(bus.pht_we[1]);
    check("bp_extra_dropped", 64'(extraSeen), 64'd0);
    check("bp_drained", 64'(drained), 64'(2 * nFill));

    // Reset with five entries pending: nothing stale may be written afterwards.
    for (int i = 0; i < 4; i++)
      cycle(mk(2'b11, 2'b11, 2'b01, 2'b00, 32'h504, 32'h504, 1, 2, 1, 1));
    doReset();
    for (int i = 0; i < 3; i++) cycle(idle);

    // Random traffic against the queue model; indices cluster to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      rv.valid   = (i < 200) ? (2'($urandom) & 2'($urandom)) : 2'($urandom);
      rv.cond    = 2'($urandom) | 2'($urandom);
      rv.taken   = 2'($urandom);
      rv.mispred = 2'($urandom) & 2'($urandom);
      for (int l = 0; l < 2; l++) begin
        rv.addr[l] = $urandom;
        if ($urandom_range(0, 2) != 0) rv.addr[l][9:2] = 8'h20 + 8'($urandom_range(0, 2));
        rv.hist[l] = 2'($urandom);
        rv.ctr[l]  = 2'($urandom);
      end
      cycle(rv);
    end
    for (int i = 0; i < 12; i++) cycle(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
